spi_keycode_slave: RTL
======================

SPI_KEYCODE_SLAVE -- requirements
Module: spi_keycode_slave

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000000, Clk cycles without a valid frame before keycode auto-clears (100 ms at 50 MHz).
REQ-002 SHALL have port Clk  input  1  system clock, 50 MHz (MAX10_CLK1_50).
REQ-003 SHALL have port Reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port SCLK  input  1  SPI clock from external master, asynchronous to Clk.
REQ-005 SHALL have port SS_n  input  1  SPI slave select, active-low, asynchronous.
REQ-006 SHALL have port MOSI  input  1  SPI master-out data, asynchronous.
REQ-007 SHALL have port scoreL  input  4  left player score, sampled at frame start.
REQ-008 SHALL have port scoreR  input  4  right player score, sampled at frame start.
REQ-009 SHALL have port MISO  output  1  SPI slave-out data.
REQ-010 SHALL have port MISO_oe  output  1  MISO drive enable; top level tri-states the pin when 0.
REQ-011 SHALL have port keycode  output  8  last committed keycode, same meaning as the USB keycode bus.
REQ-012 SHALL have port keycode_valid  output  1  one-cycle pulse on commit.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on rejected frame.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse on keycode auto-clear.

Function
REQ-015 SHALL pass SCLK, SS_n, MOSI each through a 2-flop synchronizer; all edge detection uses synchronized values only.
REQ-016 SHALL support SPI mode 0, MSB first; master limits SCLK to at most Clk/8 and SS_n-fall to first SCLK rise at least 4 Clk periods.
REQ-017 SHALL implement states IDLE, BYTE0, BYTE1, OVERRUN, WAIT_IDLE.
REQ-018 IDLE: on synchronized SS_n fall -> BYTE0; load tx shift register with {scoreL, scoreR}; clear bit counter; MISO_oe=1.
REQ-019 On each synchronized SCLK rise, SHALL shift MOSI into rx register LSB side and increment 3-bit bit counter.
REQ-020 On each synchronized SCLK fall, SHALL shift tx register left; MISO = tx[7] at all times while MISO_oe=1.
REQ-021 BYTE0, 8th rise: store rx as candidate; reload tx with 8'hA5 before the next SCLK fall; -> BYTE1.
REQ-022 BYTE1, 8th rise: store rx as check byte; -> OVERRUN (armed-complete flag set).
REQ-023 Any further SCLK rise in OVERRUN SHALL clear armed-complete flag; no additional shifting affects outputs.
REQ-024 On synchronized SS_n rise in any of BYTE0/BYTE1/OVERRUN -> IDLE, MISO_oe=0, and SHALL evaluate the frame in that same cycle.
REQ-025 Commit when armed-complete and check == ~candidate: keycode <= candidate, keycode_valid=1 next cycle, timeout counter cleared.
REQ-026 Otherwise (short frame, long frame, check mismatch): frame_err=1 for one cycle, keycode unchanged.
REQ-027 Total latency from SS_n pin rise to keycode update SHALL be at most 4 Clk cycles.
REQ-028 Timeout counter SHALL increment every Clk not clearing; at TIMEOUT_CYCLES-1 with keycode != 0: keycode <= 0, timeout=1 one cycle, counter cleared; with keycode == 0 counter saturates silently.
REQ-029 Commit and timeout in the same cycle: commit wins, no timeout pulse.
REQ-030 keycode_valid, frame_err, timeout SHALL be mutually exclusive in any cycle.
REQ-031 Candidate 8'h00 with check 8'hFF SHALL commit as a valid release keycode.

Reset
REQ-032 On Reset: state IDLE, keycode=0, MISO=0, MISO_oe=0, all pulses 0, counters and shift registers 0.
REQ-033 If synchronized SS_n is low when Reset deasserts, SHALL enter WAIT_IDLE and ignore traffic until SS_n high is seen, then IDLE.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no commit and no frame_err pulse.

Verification
REQ-035 Frame MOSI 8'h1A,8'hE5 with scoreL=3, scoreR=7 -> MISO returns 8'h37,8'hA5; keycode=8'h1A; single keycode_valid pulse.
REQ-036 Frame 8'h1A,8'h00 -> frame_err pulse; keycode holds prior value 8'h1A.
REQ-037 SS_n high after 12 bits, then after 17 bits -> frame_err each time; keycode unchanged; MISO_oe=0 after each.
REQ-038 TIMEOUT_CYCLES=1000, commit 8'h07, idle -> keycode=0 and timeout pulse exactly 1000 cycles after commit; no further pulses.
REQ-039 Reset pulsed after 5 bits of frame with SS_n held low, then 11 more bits -> no commit, no frame_err; next clean frame 8'h16,8'hE9 commits 8'h16.
REQ-040 SCLK at Clk/8 with random SS_n/SCLK phase vs Clk over 1000 valid frames -> every frame commits, zero frame_err.

Source files
------------

// File: rtl/spi_keycode_slave.sv
// SPI mode-0 slave that receives a two-byte keycode frame {keycode, ~keycode}.
// While receiving it returns {scoreL, scoreR} followed by 8'hA5 on MISO.
// Good frames are committed to the keycode output. A keycode that is not
// refreshed within TIMEOUT_CYCLES clocks is auto-cleared to 0.
module spi_keycode_slave #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       SCLK,
    input  logic       SS_n,
    input  logic       MOSI,
    input  logic [3:0] scoreL,
    input  logic [3:0] scoreR,
    output logic       MISO,
    output logic       MISO_oe,
    output logic [7:0] keycode,
    output logic       keycode_valid,
    output logic       frame_err,
    output logic       timeout
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_BYTE1,
        S_OVERRUN,
        S_WAIT_IDLE
    } state_t;

    logic [1:0]    r_sclk_sync;
    logic [1:0]    r_ss_sync;
    logic [1:0]    r_mosi_sync;
    logic          r_sclk_prev;
    logic          r_ss_prev;

    state_t        r_state;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_cand;
    logic [7:0]    r_check;
    logic          r_armed;
    logic [TW-1:0] r_to_cnt;

    logic w_sclk;
    logic w_ss;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_rise;
    logic w_in_frame;
    logic w_eval;
    logic w_good;
    logic w_commit;
    logic w_reject;
    logic [7:0] w_rx_next;

    // Two-flop synchronizers for the asynchronous SPI pins, plus one delayed copy for edge detection.
    // NOTE: these flops are deliberately not reset so they keep tracking the pins
    // through Reset; that lets the FSM see SS_n already low when Reset drops
    // instead of inventing a false SS_n fall one cycle later.
    always_ff @(posedge Clk) begin
        r_sclk_sync <= {r_sclk_sync[0], SCLK};
        r_ss_sync   <= {r_ss_sync[0], SS_n};
        r_mosi_sync <= {r_mosi_sync[0], MOSI};
        r_sclk_prev <= r_sclk_sync[1];
        r_ss_prev   <= r_ss_sync[1];
    end

    assign w_sclk      = r_sclk_sync[1];
    assign w_ss        = r_ss_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_ss_rise   = w_ss & ~r_ss_prev;
    assign w_rx_next   = {r_rx[6:0], w_mosi};

    // Frame verdict, taken in the same cycle the synchronized SS_n rises.
    assign w_in_frame = (r_state == S_BYTE0) || (r_state == S_BYTE1) || (r_state == S_OVERRUN);
    assign w_eval     = w_in_frame & w_ss_rise;
    assign w_good     = r_armed && (r_check == ~r_cand);
    assign w_commit   = w_eval & w_good;
    assign w_reject   = w_eval & ~w_good;

    assign MISO = r_tx[7] & MISO_oe;

    // Frame FSM, shift registers, keycode register and the idle timeout.
    // NOTE: all state here uses non-blocking assignments so every branch reads
    // the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_tx          <= 8'h00;
            r_rx          <= 8'h00;
            r_bit_cnt     <= 3'd0;
            r_cand        <= 8'h00;
            r_check       <= 8'h00;
            r_armed       <= 1'b0;
            r_to_cnt      <= '0;
            MISO_oe       <= 1'b0;
            keycode       <= 8'h00;
            keycode_valid <= 1'b0;
            frame_err     <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            keycode_valid <= 1'b0;
            frame_err     <= 1'b0;
            timeout       <= 1'b0;

            // A commit restarts the idle window. A timeout that lands on a
            // rejected frame is held one cycle so the pulses never overlap.
            if (w_commit) begin
                keycode       <= r_cand;
                keycode_valid <= 1'b1;
                r_to_cnt      <= '0;
            end else if (r_to_cnt == TO_LAST) begin
                if (keycode != 8'h00 && !w_reject) begin
                    keycode  <= 8'h00;
                    timeout  <= 1'b1;
                    r_to_cnt <= '0;
                end
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_reject) begin
                frame_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_ss) begin
                        if (r_ss_prev) begin
                            r_state   <= S_BYTE0;
                            r_tx      <= {scoreL, scoreR};
                            r_bit_cnt <= 3'd0;
                            r_armed   <= 1'b0;
                            MISO_oe   <= 1'b1;
                        end else begin
                            // SS_n was already low with no fall seen: joined mid-frame.
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                end

                S_BYTE0, S_BYTE1, S_OVERRUN: begin
                    if (w_ss_rise) begin
                        r_state <= S_IDLE;
                        MISO_oe <= 1'b0;
                    end else if (w_sclk_rise) begin
                        if (r_state == S_OVERRUN) begin
                            r_armed <= 1'b0;
                        end else begin
                            r_rx      <= w_rx_next;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == S_BYTE0) begin
                                    r_cand  <= w_rx_next;
                                    r_tx    <= 8'hA5;
                                    r_state <= S_BYTE1;
                                end else begin
                                    r_check <= w_rx_next;
                                    r_armed <= 1'b1;
                                    r_state <= S_OVERRUN;
                                end
                            end
                        end
                    end else if (w_sclk_fall) begin
                        // The fall right after the 8th rise must present bit 7 of
                        // the freshly loaded 8'hA5, so that one fall does not shift.
                        if (!(r_state == S_BYTE1 && r_bit_cnt == 3'd0)) begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (w_ss) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
